// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with a registered read port,
// occupancy flags and sticky overflow/underflow error flags.
//
// Ports:
//   clk          single clock; all state updates on its rising edge
//   reset        asynchronous, active-high reset
//   wr_en        write request (accepted when not full)
//   wdata        write data, WIDTH bits
//   rd_en        read request (accepted when not empty)
//   err_clr      synchronous clear of overflow/underflow
//   rdata        registered read data; holds when no read is accepted
//   rvalid       one-cycle pulse marking a newly read word on rdata
//   full/empty   occupancy == DEPTH / == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: write requested while full
//   underflow    sticky: read requested while empty
module sync_fifo_buf #(
  parameter int WIDTH    = 8,
  parameter int ADDR     = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2 ** ADDR;

  // Thresholds expressed in the count register's width.
  localparam logic [ADDR:0] FULL_CNT = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_CNT   = AF_LEVEL[ADDR:0];
  localparam logic [ADDR:0] AE_CNT   = AE_LEVEL[ADDR:0];

  // Storage: no reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDR-1:0]  wptr_reg, wptr_next;
  logic [ADDR-1:0]  rptr_reg, rptr_next;
  logic [ADDR:0]    count_reg, count_next;
  logic [WIDTH-1:0] rdata_reg;
  logic             rvalid_reg;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  logic full_flag;
  logic empty_flag;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the count register so they line up with count.
  assign full_flag  = (count_reg == FULL_CNT);
  assign empty_flag = (count_reg == '0);

  // Full/empty are sampled before the edge: when full a simultaneous read
  // still goes through while the write is dropped, and vice versa when empty.
  assign wr_acc = wr_en && !full_flag;
  assign rd_acc = rd_en && !empty_flag;

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    // Pointers are exactly ADDR bits, so DEPTH-1 -> 0 wraps naturally.
    if (wr_acc) begin
      wptr_next = wptr_reg + ADDR'(1);
    end
    if (rd_acc) begin
      rptr_next = rptr_reg + ADDR'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + (ADDR+1)'(1);
      2'b01:   count_next = count_reg - (ADDR+1)'(1);
      default: count_next = count_reg;
    endcase

    // A fresh error in the same cycle as err_clr wins and keeps the flag set.
    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr_en && full_flag) begin
      overflow_next = 1'b1;
    end
    if (rd_en && empty_flag) begin
      underflow_next = 1'b1;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_reg] <= wdata;
    end
  end

  // Control state and registered read port. The read uses the old
  // mem[rptr] even if the same entry is written this cycle; no bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      count_reg     <= count_next;
      rvalid_reg    <= rd_acc;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (rd_acc) begin
        rdata_reg <= mem[rptr_reg];
      end
    end
  end

  assign rdata        = rdata_reg;
  assign rvalid       = rvalid_reg;
  assign full         = full_flag;
  assign empty        = empty_flag;
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Directed testbench for sync_fifo_buf with default parameters
// (WIDTH 8, DEPTH 32, AF_LEVEL 28, AE_LEVEL 4).
module tb_sync_fifo_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wdata;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] count;
  logic       overflow;
  logic       underflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_word;

  sync_fifo_buf dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_ae"}, 32'(almost_empty), 32'd1);
    check({tag, "_af"}, 32'(almost_full), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_udf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wdata   = 8'h00;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;

    // Fill 0x01..0x20.
    wr_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      wdata = 8'(i);
      tick();
      check($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      check($sformatf("fill%0d_af", i), 32'(almost_full), (i >= 28) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d_full", i), 32'(full), (i == 32) ? 32'd1 : 32'd0);
    end

    // Write into a full FIFO: dropped, overflow set.
    wdata = 8'hAA;
    tick();
    wr_en = 1'b0;
    check("ovf_count", 32'(count), 32'd32);
    check("ovf_flag", 32'(overflow), 32'd1);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Drain 0x01..0x20.
    rd_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("drain%0d_rvalid", i), 32'(rvalid), 32'd1);
      check($sformatf("drain%0d_rdata", i), 32'(rdata), 32'(i));
      check($sformatf("drain%0d_count", i), 32'(count), 32'(32 - i));
      check($sformatf("drain%0d_ae", i), 32'(almost_empty), (32 - i <= 4) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
    tick();
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_rdata_hold", 32'(rdata), 32'h20);
    check("drained_empty", 32'(empty), 32'd1);

    // Read from empty: no rvalid, rdata held, underflow set.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_rvalid", 32'(rvalid), 32'd0);
    check("udf_rdata", 32'(rdata), 32'h20);
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("udf_clr", 32'(underflow), 32'd0);

    // Error in the same cycle as err_clr keeps the flag.
    rd_en   = 1'b1;
    err_clr = 1'b1;
    tick();
    rd_en   = 1'b0;
    err_clr = 1'b0;
    check("udf_prio", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Empty with write+read: write wins, read rejected.
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("ew_count", 32'(count), 32'd1);
    check("ew_udf", 32'(underflow), 32'd1);
    check("ew_rvalid", 32'(rvalid), 32'd0);
    err_clr = 1'b1;
    rd_en   = 1'b1;
    tick();
    err_clr = 1'b0;
    rd_en   = 1'b0;
    check("ew_read_rdata", 32'(rdata), 32'h77);
    check("ew_read_rvalid", 32'(rvalid), 32'd1);
    check("ew_udf_clr", 32'(underflow), 32'd0);

    // Steady state at count 10 for 50 cycles of simultaneous traffic.
    wr_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata = 8'h80 + 8'(k);
      model_q.push_back(wdata);
      tick();
    end
    check("ss_start_count", 32'(count), 32'd10);
    rd_en = 1'b1;
    for (int j = 0; j < 50; j++) begin
      wdata = 8'h90 + 8'(j);
      model_q.push_back(wdata);
      exp_word = model_q.pop_front();
      tick();
      check($sformatf("ss%0d_count", j), 32'(count), 32'd10);
      check($sformatf("ss%0d_rdata", j), 32'(rdata), 32'(exp_word));
      check($sformatf("ss%0d_rvalid", j), 32'(rvalid), 32'd1);
    end
    wr_en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      exp_word = model_q.pop_front();
      tick();
      check($sformatf("ssd%0d_rdata", j), 32'(rdata), 32'(exp_word));
    end
    rd_en = 1'b0;
    tick();
    check("ssd_empty", 32'(empty), 32'd1);

    // Full with write+read: read wins, write dropped.
    wr_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wdata = 8'h40 + 8'(i);
      tick();
    end
    check("fw_full", 32'(full), 32'd1);
    rd_en = 1'b1;
    wdata = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("fw_count", 32'(count), 32'd31);
    check("fw_ovf", 32'(overflow), 32'd1);
    check("fw_rvalid", 32'(rvalid), 32'd1);
    check("fw_rdata", 32'(rdata), 32'h40);
    for (int i = 1; i < 32; i++) begin
      tick();
      check($sformatf("fwd%0d_rdata", i), 32'(rdata), 32'h40 + 32'(i));
    end
    rd_en   = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("fwd_empty", 32'(empty), 32'd1);
    check("fwd_ovf_clr", 32'(overflow), 32'd0);

    // Reset mid-burst at count 17.
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wdata = 8'hC0 + 8'(i);
      tick();
    end
    check("mid_count", 32'(count), 32'd17);
    rd_en = 1'b1;
    tick();
    check("mid_rvalid", 32'(rvalid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    check_reset_values("midrst_hold");
    reset = 1'b0;
    wr_en = 1'b1;
    wdata = 8'h55;
    tick();
    wr_en = 1'b0;
    check("post_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rdata", 32'(rdata), 32'h55);
    check("post_rvalid", 32'(rvalid), 32'd1);
    check("post_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_buf.md
SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter ADDR, default 5, address width; DEPTH SHALL equal 2**ADDR (default 32 entries).
REQ-003 Parameter AF_LEVEL, default 28, almost_full threshold; SHALL be in 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 4, almost_empty threshold; SHALL be in 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 rd_en  input  1  read request.
REQ-010 err_clr  input  1  synchronous clear of sticky error flags.
REQ-011 rdata  output  WIDTH  registered read data.
REQ-012 rvalid  output  1  one-cycle pulse; rdata holds newly read word.
REQ-013 full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 almost_full / almost_empty  output  1 each  count >= AF_LEVEL / count <= AE_LEVEL.
REQ-015 count  output  ADDR+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accept SHALL be wr_en && !full, with full sampled before the edge; on accept, mem[wptr] <= wdata and wptr increments.
REQ-018 Read accept SHALL be rd_en && !empty, with empty sampled before the edge; on accept, rdata <= mem[rptr], rptr increments, and rvalid = 1 the following cycle.
REQ-019 Read latency SHALL be one cycle from the accepting edge; rdata SHALL hold its value when no read is accepted; rvalid SHALL be 0 otherwise.
REQ-020 wptr and rptr SHALL be ADDR bits wide and wrap DEPTH-1 -> 0 with no extra logic.
REQ-021 count SHALL be +1 on write-only accept, -1 on read-only accept, and unchanged on simultaneous accept or no accept.
REQ-022 When full, simultaneous wr_en and rd_en: the read SHALL be accepted, the write rejected, overflow set; count becomes DEPTH-1.
REQ-023 When empty, simultaneous wr_en and rd_en: the write SHALL be accepted, the read rejected, underflow set; rvalid stays 0; count becomes 1.
REQ-024 Non-empty and non-full, simultaneous accept: the read SHALL return the old mem[rptr]; no write-through bypass.
REQ-025 overflow SHALL set on wr_en && full; underflow SHALL set on rd_en && empty; both hold until err_clr or reset.
REQ-026 err_clr SHALL clear both flags, except that a new error in the same cycle takes priority and keeps the flag set.
REQ-027 full, empty, almost_full and almost_empty SHALL be decoded from the count register, so they are valid in the same cycle as count.
REQ-028 Rejected requests SHALL change no pointer, memory word or count.

Reset
REQ-029 On reset = 1, the block SHALL immediately set wptr = 0, rptr = 0, count = 0, rdata = 0, rvalid = 0, overflow = 0, underflow = 0.
REQ-030 Consequently, during reset empty = 1, full = 0, almost_empty = 1, and almost_full = 0 (for AF_LEVEL >= 1).
REQ-031 Memory array contents SHALL NOT be reset; no read can return them before they are written.
REQ-032 Reset asserted mid-operation SHALL discard all stored data; the first write after release SHALL land in mem[0].

Verification
REQ-033 Reset, then write 0x01..0x20 (32 words) -> count 1..32, almost_full rises at count 28, full = 1 after the 32nd write; then read 32 -> rdata 0x01..0x20, each with an rvalid pulse, empty = 1 at end.
REQ-034 Full FIFO, wr_en = 1 with wdata 0xAA -> no count change, overflow = 1 next cycle; err_clr for 1 cycle -> overflow = 0.
REQ-035 Empty FIFO, rd_en = 1 -> rvalid stays 0, rdata unchanged, underflow = 1.
REQ-036 Count 10, wr_en and rd_en together for 50 cycles -> count stays 10, pointers wrap, read data in exact write order.
REQ-037 Full with wr_en and rd_en together -> read accepted, count 31, overflow = 1; empty with both -> count 1, underflow = 1, rvalid = 0.
REQ-038 Reset pulsed at count 17 mid-burst -> all outputs at reset values within the reset cycle; write 0x55 then read -> rdata 0x55.
